// File: rtl/fir_tap_window_8x16.sv
// Sliding TAPS-deep delay line that presents the parallel tap window over valid/ready,
// emitting one registered window every DECIM accepted samples once the line is full.
module fir_tap_window_8x16 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned DECIM  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [DATA_W*TAPS-1:0]     win_data,
  output logic [$clog2(TAPS+1)-1:0]  fill_count
);

  localparam int unsigned CntW   = $clog2(TAPS + 1);
  localparam int unsigned PhaseW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e                       state_q;
  logic [TAPS-1:0][DATA_W-1:0]  sr_q;
  logic [TAPS-1:0][DATA_W-1:0]  sr_shift;
  logic [CntW-1:0]              fill_q;
  logic [PhaseW-1:0]            phase_q;
  logic                         win_valid_q;
  logic [DATA_W*TAPS-1:0]       win_data_q;
  logic                         will_emit;
  logic                         accept;

  // sr[0] is the newest sample; a shift moves every slot one step toward the oldest tap.
  always_comb begin
    sr_shift = {sr_q[TAPS-2:0], in_data};
    if (state_q == StFill) begin
      will_emit = (fill_q == CntW'(TAPS - 1));
    end else begin
      will_emit = (phase_q == PhaseW'(DECIM - 1));
    end
  end

  // Only an emitting sample needs a free output slot; others are always taken.
  assign in_ready = !flush && (!will_emit || !win_valid_q || win_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      sr_q        <= '0;
      fill_q      <= '0;
      phase_q     <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
    end else if (flush) begin
      state_q     <= StFill;
      sr_q        <= '0;
      fill_q      <= '0;
      phase_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      if (win_valid_q && win_ready) begin
        win_valid_q <= 1'b0;
      end
      if (accept) begin
        sr_q <= sr_shift;
        if (state_q == StFill) begin
          fill_q <= fill_q + 1'b1;
          if (will_emit) begin
            state_q <= StRun;
            phase_q <= '0;
          end
        end else begin
          phase_q <= will_emit ? '0 : phase_q + 1'b1;
        end
        if (will_emit) begin
          win_data_q  <= sr_shift;
          win_valid_q <= 1'b1;
        end
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_fir_tap_window_8x16.sv
// Scoreboard bench: two instances (DECIM=1 and DECIM=4) share one stimulus stream and are
// each checked against a sample-history reference model.
module tb_fir_tap_window_8x16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = '0;
  logic         flush = 1'b0;
  logic         win_ready = 1'b0;

  logic         rdy [2];
  logic         wv  [2];
  logic [127:0] wd  [2];
  logic [3:0]   fc  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Downstream summer: tap k weighted by k+1.
  function automatic int summer(input logic [127:0] w);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'(w[k*16 +: 16]) * (k + 1);
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 1 : 4;

    fir_tap_window_8x16 #(
      .DATA_W(16),
      .TAPS  (8),
      .DECIM (D)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_data   (in_data),
      .flush     (flush),
      .win_valid (wv[g]),
      .win_ready (win_ready),
      .win_data  (wd[g]),
      .fill_count(fc[g])
    );

    logic [127:0] expq [$];
    logic [15:0]  hist [$];
    int           cnt = 0;
    bit           slot = 1'b0;
    bit           ew, er, acc;
    logic [127:0] w;

    // Reference model: counts accepts since the last clear and keeps the last 8 samples.
    always @(negedge clk) begin
      if (rst || flush) begin
        hist.delete();
        expq.delete();
        cnt  = 0;
        slot = 1'b0;
      end else begin
        ew = (cnt + 1 >= 8) && (((cnt + 1 - 8) % D) == 0);
        er = !ew || !slot || win_ready;
        check($sformatf("in_ready[%0d]", g), rdy[g], er);
        check($sformatf("win_valid[%0d]", g), wv[g], slot);
        check($sformatf("fill_count[%0d]", g), fc[g], (cnt >= 8) ? 8 : cnt);
        if (slot && win_ready) slot = 1'b0;
        acc = in_valid && er;
        if (acc) begin
          hist.push_back(in_data);
          if (hist.size() > 8) void'(hist.pop_front());
          cnt++;
          if (ew) begin
            w = '0;
            for (int k = 0; k < 8; k++) w[k*16 +: 16] = hist[hist.size() - 1 - k];
            expq.push_back(w);
            slot = 1'b1;
          end
        end
      end
    end

    // Monitor: every cycle a window is presented it must match the oldest expected one.
    always @(negedge clk) begin
      if (!rst && !flush && wv[g]) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL win_unexpected[%0d]: got window %0h want none", g, wd[g]);
        end else begin
          check($sformatf("win_data[%0d]", g), wd[g], expq[0]);
          if (win_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [15:0] d, input bit wr, input bit f,
                       input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    win_ready = wr;
    flush     = f;
    rst       = r;
  endtask

  task automatic check_reset_state();
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_win_valid", wv[g], 0);
      check("rst_win_data", wd[g], 0);
      check("rst_fill_count", fc[g], 0);
    end
  endtask

  initial begin
    repeat (2) drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 0);
    check_reset_state();

    // Fill with 1..8, then continue with 9.
    for (int i = 1; i <= 8; i++) drive(1, 16'(i), 1, 0, 0);
    drive(1, 9, 1, 0, 0);
    #1;
    check("summer_first", summer(wd[0]), 120);
    drive(0, 0, 0, 0, 0);
    #1;
    check("summer_second", summer(wd[0]), 156);

    // Stall with a window pending, then release.
    drive(1, 10, 0, 0, 0);
    #1;
    check("stall_in_ready", rdy[0], 0);
    repeat (3) drive(1, 10, 0, 0, 0);
    drive(1, 10, 1, 0, 0);
    #1;
    check("release_in_ready", rdy[0], 1);
    drive(0, 0, 1, 0, 0);
    #1;
    check("release_tap0", wd[0][15:0], 10);

    // Decimation run 1..20.
    drive(0, 0, 1, 1, 0);
    for (int i = 1; i <= 20; i++) drive(1, 16'(i), 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    #1;
    check("decim_tap0", wd[1][15:0], 20);
    check("decim_valid", wv[1], 1);

    // Flush with in_valid at fill_count=5.
    drive(0, 0, 1, 1, 0);
    for (int i = 1; i <= 5; i++) drive(1, 16'(i), 1, 0, 0);
    drive(1, 99, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    #1;
    check("flush_fill0", fc[0], 0);
    check("flush_fill1", fc[1], 0);
    check("flush_valid0", wv[0], 0);
    for (int i = 1; i <= 8; i++) drive(1, 16'(100 + i), 1, 0, 0);

    // Reset in RUN with a window pending, then refill.
    repeat (3) drive(1, 16'(200), 0, 0, 0);
    drive(1, 55, 0, 0, 1);
    drive(0, 0, 1, 0, 0);
    check_reset_state();
    for (int i = 1; i <= 8; i++) drive(1, 16'(i), 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    #1;
    check("summer_after_rst", summer(wd[0]), 120);

    // Randomized traffic with occasional flush and reset.
    repeat (3000) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (5) drive(0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
